// File: rtl/ram_sp_init_pkg.sv
// Shared types and constants for the initialised single-port RAM.
package ram_sp_init_pkg;

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam int BYTE_W = 8;
  localparam int BE_W   = 16 / BYTE_W;

  function automatic int be_width(input int data_w);
    return data_w / BYTE_W;
  endfunction

endpackage

// File: rtl/ram_sp_core.sv
// Plain synchronous word array with a byte-enable write port and a registered read port.
module ram_sp_core
  import ram_sp_init_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 14,
  parameter int DEPTH  = 16384
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          wr_en,
  input  logic [be_width(DATA_W)-1:0]   wr_be,
  input  logic                          rd_en,
  input  logic                          rd_zero,
  input  logic [ADDR_W-1:0]             addr,
  input  logic [DATA_W-1:0]             wr_data,
  output logic [DATA_W-1:0]             rd_data
);

  localparam int NBE = be_width(DATA_W);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rd_data_d;
  logic [DATA_W-1:0] rd_data_q;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < NBE; i++) begin
        if (wr_be[i]) begin
          mem_q[addr][i*BYTE_W +: BYTE_W] <= wr_data[i*BYTE_W +: BYTE_W];
        end
      end
    end
  end

  // Out-of-range reads return zero; the array is never indexed for them.
  always_comb begin
    rd_data_d = rd_data_q;
    if (rd_en) begin
      if (rd_zero) begin
        rd_data_d = '0;
      end else begin
        rd_data_d = mem_q[addr];
      end
    end else begin
      rd_data_d = rd_data_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/ram_sp_init.sv
// Single-port RAM with ready/valid requests, byte enables, range check and a post-reset clear sweep.
module ram_sp_init
  import ram_sp_init_pkg::*;
#(
  parameter int                      DATA_W   = 16,
  parameter int                      ADDR_W   = 14,
  parameter int                      DEPTH    = 16384,
  parameter logic [DATA_W-1:0]       INIT_VAL = '0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        en,
  input  logic                        req_valid,
  output logic                        req_ready,
  input  logic                        we,
  input  logic [ADDR_W-1:0]           addr,
  input  logic [DATA_W-1:0]           din,
  input  logic [be_width(DATA_W)-1:0] be,
  output logic [DATA_W-1:0]           dout,
  output logic                        dout_valid,
  output logic                        err,
  output logic                        init_done
);

  localparam int NBE   = be_width(DATA_W);
  localparam int CNT_W = ADDR_W + 1;
  // One extra counter bit lets DEPTH == 2**ADDR_W terminate without wrapping.
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] DEPTH_M1 = CNT_W'(DEPTH - 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              dout_valid_q, dout_valid_d;
  logic              err_q, err_d;

  logic              accept;
  logic              in_range;
  logic              core_wr_en;
  logic [NBE-1:0]    core_be;
  logic              core_rd_en;
  logic              core_rd_zero;
  logic [ADDR_W-1:0] core_addr;
  logic [DATA_W-1:0] core_wdata;

  assign init_done = (state_q == ST_RUN);
  assign req_ready = init_done & en;
  assign accept    = req_valid & req_ready;
  assign in_range  = ({1'b0, addr} < DEPTH_C);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    core_wr_en   = 1'b0;
    core_be      = '0;
    core_addr    = addr;
    core_wdata   = din;
    core_rd_en   = 1'b0;
    core_rd_zero = 1'b0;
    dout_valid_d = 1'b0;
    err_d        = 1'b0;
    case (state_q)
      ST_INIT: begin
        core_wr_en = 1'b1;
        core_be    = '1;
        core_addr  = cnt_q[ADDR_W-1:0];
        core_wdata = INIT_VAL;
        cnt_d      = cnt_q + CNT_W'(1);
        if (cnt_q == DEPTH_M1) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_INIT;
        end
      end
      ST_RUN: begin
        if (accept) begin
          core_wr_en   = we & in_range;
          core_be      = be;
          core_rd_en   = ~we;
          core_rd_zero = ~in_range;
          dout_valid_d = ~we;
          err_d        = ~in_range;
        end else begin
          core_wr_en   = 1'b0;
          core_rd_en   = 1'b0;
        end
      end
      default: begin
        state_d = ST_INIT;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_INIT;
      cnt_q        <= '0;
      dout_valid_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      dout_valid_q <= dout_valid_d;
      err_q        <= err_d;
    end
  end

  ram_sp_core #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_core (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (core_wr_en),
    .wr_be   (core_be),
    .rd_en   (core_rd_en),
    .rd_zero (core_rd_zero),
    .addr    (core_addr),
    .wr_data (core_wdata),
    .rd_data (dout)
  );

  assign dout_valid = dout_valid_q;
  assign err        = err_q;

endmodule
